// File: rtl/uart_imem_loader.sv
// Assembles UART bytes into little-endian words and writes them to instruction memory,
// holding the core in reset until an end marker or the word limit completes loading.
//
// state  | meaning
// LOAD   | collecting bytes of the current word
// COMMIT | one cycle: write the assembled word or recognise the end marker
// DONE   | loading complete, core released, rx input ignored
module uart_imem_loader #(
  parameter int WORD_BYTES     = 4,
  parameter int ADDR_W         = 8,
  parameter int MAX_WORDS      = 256,
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int END_MARKER_EN  = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx_en,
  input  logic                      rx_valid,
  input  logic [7:0]                rx_data,
  input  logic                      rx_break,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [8*WORD_BYTES-1:0]   mem_wdata,
  output logic [ADDR_W:0]           word_count,
  output logic                      write_done,
  output logic                      core_rst,
  output logic [1:0]                err
);

  localparam int W  = 8 * WORD_BYTES;
  localparam int BW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int CW = ADDR_W + 1;

  localparam logic [BW-1:0] LAST_IDX = BW'(WORD_BYTES - 1);
  localparam logic [TW-1:0] TIMER_TC = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_WORDS - 1);

  typedef enum logic [1:0] {LOAD, COMMIT, DONE} state_t;

  state_t            state;
  state_t            state_d;
  logic [BW-1:0]     byte_idx;
  logic [TW-1:0]     timer;
  logic [W-1:0]      word_q;
  logic [CW-1:0]     count_q;
  logic [ADDR_W-1:0] addr_hold;
  logic [W-1:0]      data_hold;
  logic [1:0]        err_q;

  logic partial;
  logic brk;
  logic take_load;
  logic take_commit;
  logic last_byte;
  logic marker;

  assign partial     = (byte_idx != '0);
  assign brk         = rx_en & rx_break;
  assign take_load   = rx_en & rx_valid & ~rx_break;
  assign take_commit = rx_en & rx_valid;
  assign last_byte   = (byte_idx == LAST_IDX);
  assign marker      = (END_MARKER_EN != 0) && (word_q == '1);

  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_d;
  end

  // With one-byte words a byte accepted during COMMIT completes the next word immediately.
  always_comb begin
    state_d = state;
    case (state)
      LOAD:    if (take_load && last_byte) state_d = COMMIT;
      COMMIT: begin
        if (marker || count_q == LAST_CNT) state_d = DONE;
        else if (take_commit && last_byte) state_d = COMMIT;
        else                               state_d = LOAD;
      end
      DONE:    state_d = DONE;
      default: state_d = LOAD;
    endcase
  end

  always_comb begin
    mem_we     = (state == COMMIT) && !marker;
    mem_addr   = mem_we ? count_q[ADDR_W-1:0] : addr_hold;
    mem_wdata  = mem_we ? word_q : data_hold;
    word_count = count_q;
    write_done = (state == DONE);
    core_rst   = (state != DONE);
    err        = err_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_idx  <= '0;
      timer     <= '0;
      word_q    <= '0;
      count_q   <= '0;
      addr_hold <= '0;
      data_hold <= '0;
      err_q     <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (brk) begin
            if (partial) err_q[1] <= 1'b1;
            byte_idx <= '0;
            timer    <= '0;
          end else if (take_load) begin
            word_q[8*byte_idx +: 8] <= rx_data;
            byte_idx <= last_byte ? '0 : byte_idx + BW'(1);
            timer    <= '0;
          end else if (partial && timer == TIMER_TC) begin
            byte_idx <= '0;
            timer    <= '0;
            err_q[0] <= 1'b1;
          end else if (partial) begin
            timer <= timer + TW'(1);
          end
        end
        COMMIT: begin
          if (mem_we) begin
            count_q   <= count_q + CW'(1);
            addr_hold <= count_q[ADDR_W-1:0];
            data_hold <= word_q;
          end
          // A byte arriving in the commit cycle starts the next word unless loading ends here.
          if (take_commit && state_d != DONE) begin
            word_q[7:0] <= rx_data;
            byte_idx    <= last_byte ? '0 : BW'(1);
            timer       <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
